alu_arbiter: RTL and testbench
==============================

# alu_arbiter

- Shares one ALU datapath between NREQ requesters (default 2: execute-stage integer ops and the address/branch-compare path).
- Arbitrates with round-robin priority, accepts one operation at a time, drives the ALU from registered operands, and captures the result.
- Returns the result to the owning requester over a valid/ready response channel.
- Sits between pipeline requesters and the single ALU instance; the ALU itself is external.

## Interface
Parameters:
- NREQ, 2, number of requesters (2..4)
- WIDTH, 32, operand/result width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- ReqValid  in  NREQ  per-requester operation request
- ReqReady  out  NREQ  per-requester accept; one-hot or zero
- ReqSrcA  in  NREQ*WIDTH  packed operand A; slice i = [i*WIDTH +: WIDTH]
- ReqSrcB  in  NREQ*WIDTH  packed operand B, same slicing
- ReqALUControl  in  NREQ*3  packed 3-bit op code, passed through to the ALU unmodified
- RspValid  out  NREQ  result available for requester i; one-hot or zero
- RspReady  in  NREQ  per-requester result consume
- RspResult  out  WIDTH  captured ALU result, shared by all requesters
- RspZero  out  1  captured ALU zero flag
- AluSrcA, AluSrcB  out  WIDTH  operands to the external ALU
- AluControl  out  3  op code to the external ALU
- AluResult  in  WIDTH  ALU result; combinational from the Alu* outputs
- AluZero  in  1  ALU zero flag

## Operation
- FSM states and transitions:
  - IDLE: waits for a request.
  - EXEC: ALU is evaluating the captured operation.
  - RESP: result is presented to the owner.
- Transitions: IDLE→EXEC on any ReqValid&ReqReady; EXEC→RESP unconditionally; RESP→IDLE on RspReady[owner].
- Arbitration (IDLE only):
  - Grant the first requester with ReqValid set, scanning from rr_ptr upward with wrap-around.
  - ReqReady[grant] is asserted combinationally. ReqReady is zero in EXEC and RESP.
  - On accept: capture SrcA, SrcB, ALUControl and the owner index; set rr_ptr = (grant+1) mod NREQ.
- AluSrcA/AluSrcB/AluControl are driven from the capture registers at all times, so they are stable throughout EXEC.
- End of EXEC: register AluResult into RspResult and AluZero into RspZero.
- RESP:
  - RspValid[owner]=1. RspResult and RspZero are held until the handshake.
  - RspReady on non-owner bits is ignored.
- A requester deasserting ReqValid before acceptance is legal; no request is latched without the handshake.
- Op codes are not validated. Unused codes (3, 7) pass through and the ALU's output is returned.
- Reset, including mid-EXEC or mid-RESP: the in-flight op is discarded with no response.
  - State goes to IDLE and rr_ptr to 0.
  - Capture registers, RspResult and RspZero clear to 0.
  - All outputs are 0.

## Timing
- Request accepted at edge N. ALU evaluates during cycle N+1 (EXEC). RspValid is high from cycle N+2.
- Minimum occupancy is 3 cycles per operation, when RspReady is already high on RspValid's first cycle. The next accept is possible at the edge ending the IDLE cycle that follows.
- ReqReady depends combinationally on ReqValid and state. RspValid depends only on registers.
- Reset values:
  - ReqReady=0 (becomes combinational in IDLE once reset is low).
  - RspValid=0, RspResult=0, RspZero=0.
  - AluSrcA=0, AluSrcB=0, AluControl=0.

## Configuration
- ALU_ARB_FIXED_PRIO_EN defined:
  - Round-robin is replaced by fixed priority: lowest index wins.
  - rr_ptr is not implemented.
- Undefined (default): round-robin as described under Operation.

## Structure
- Shared package holds:
  - State encoding constants: IDLE=0, EXEC=1, RESP=2 (2 bits).
  - ALU op code constants: AND=0, OR=1, ADD=2, SUB=4, MUL=5, SLT=6, for benches and requesters.
- One natural sub-module: rr_grant.
  - Combinational: (req, ptr) → one-hot grant.
  - Fixed-priority variant selected by the macro.

## Test plan
- Single op: req0 ADD (op 2), A=5, B=7, RspReady held high → ReqReady[0] at N; RspValid[0] at N+2 with RspResult=12, RspZero=0; back in IDLE at N+3.
- Contention: both requests held continuously, req0 SUB (op 4) 9-9, req1 OR (op 1) 0xF0|0x0F → grants alternate 0,1,0,1. Results 0 with Zero=1, and 0xFF.
  - With ALU_ARB_FIXED_PRIO_EN defined: only requester 0 is granted.
- Backpressure: req1 SLT (op 6) A=3, B=8, RspReady[1] low for 4 cycles → RspValid[1] and RspResult=1 held stable; ReqReady stays 0 throughout; release completes in 1 cycle.
- Wrong-owner ready: owner 0 in RESP, RspReady=2'b10 → no transition; RspValid stays 2'b01.
- Reset mid-op: reset asserted in EXEC of a MUL (op 5) 6*7 → next cycle all outputs 0, no RspValid ever for that op; a subsequent req1 request is granted first (rr_ptr=0 with only req1 valid).

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: controller state encoding, ALU op
// codes for requesters and benches, and a pointer-width helper.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  localparam logic [2:0] ALU_OP_AND = 3'd0;
  localparam logic [2:0] ALU_OP_OR  = 3'd1;
  localparam logic [2:0] ALU_OP_ADD = 3'd2;
  localparam logic [2:0] ALU_OP_SUB = 3'd4;
  localparam logic [2:0] ALU_OP_MUL = 3'd5;
  localparam logic [2:0] ALU_OP_SLT = 3'd6;

  // Index width for n requesters, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_grant.sv
// Combinational one-hot grant: round-robin from ptr by default, or plain
// lowest-index-wins when ALU_ARB_FIXED_PRIO_EN is defined (ptr port removed).
module alu_arbiter_rr_grant
  import alu_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int PW  = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
`ifndef ALU_ARB_FIXED_PRIO_EN
  input  logic [PW-1:0]   ptr,
`endif
  output logic [NREQ-1:0] grant
);

`ifdef ALU_ARB_FIXED_PRIO_EN

  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

`else

  logic [NREQ-1:0]   req_rot;
  logic [NREQ-1:0]   grant_rot;
  logic [2*NREQ-1:0] grant_dbl;

  // Rotate so ptr sits at bit 0, pick the lowest set bit, then rotate back.
  always_comb begin
    logic found;
    req_rot   = NREQ'({req, req} >> ptr);
    grant_rot = '0;
    found     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_rot[i]) begin
        grant_rot[i] = 1'b1;
        found        = 1'b1;
      end
    end
    grant_dbl = {{NREQ{1'b0}}, grant_rot} << ptr;
    grant     = grant_dbl[NREQ-1:0] | grant_dbl[2*NREQ-1:NREQ];
  end

`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU among NREQ requesters: accept, evaluate, respond.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       ReqValid,
  output logic [NREQ-1:0]       ReqReady,
  input  logic [NREQ*WIDTH-1:0] ReqSrcA,
  input  logic [NREQ*WIDTH-1:0] ReqSrcB,
  input  logic [NREQ*3-1:0]     ReqALUControl,
  output logic [NREQ-1:0]       RspValid,
  input  logic [NREQ-1:0]       RspReady,
  output logic [WIDTH-1:0]      RspResult,
  output logic                  RspZero,
  output logic [WIDTH-1:0]      AluSrcA,
  output logic [WIDTH-1:0]      AluSrcB,
  output logic [2:0]            AluControl,
  input  logic [WIDTH-1:0]      AluResult,
  input  logic                  AluZero
);

  localparam int PW = idx_width(NREQ);

  arb_state_e        state_q, state_d;
  logic [NREQ-1:0]   owner_q, owner_d;
  logic [WIDTH-1:0]  src_a_q, src_a_d;
  logic [WIDTH-1:0]  src_b_q, src_b_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              zero_q, zero_d;

  logic [NREQ-1:0]   grant;
  logic [WIDTH-1:0]  sel_a, sel_b;
  logic [2:0]        sel_ctrl;

`ifdef ALU_ARB_FIXED_PRIO_EN
  alu_arbiter_rr_grant #(.NREQ(NREQ)) u_grant (
    .req   (ReqValid),
    .grant (grant)
  );
`else
  logic [PW-1:0] ptr_q, ptr_d;

  alu_arbiter_rr_grant #(.NREQ(NREQ)) u_grant (
    .req   (ReqValid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  always_comb begin
    ptr_d = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (ReqReady[i]) ptr_d = (i == NREQ-1) ? '0 : PW'(i + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`endif

  // Accept is gated by reset so nothing is offered while reset is held.
  assign ReqReady = (state_q == ST_IDLE && !reset) ? grant : '0;

  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_ctrl = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a    = ReqSrcA[i*WIDTH +: WIDTH];
        sel_b    = ReqSrcB[i*WIDTH +: WIDTH];
        sel_ctrl = ReqALUControl[i*3 +: 3];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    src_a_d  = src_a_q;
    src_b_d  = src_b_q;
    ctrl_d   = ctrl_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (|ReqReady) begin
          state_d = ST_EXEC;
          owner_d = grant;
          src_a_d = sel_a;
          src_b_d = sel_b;
          ctrl_d  = sel_ctrl;
        end
      end
      ST_EXEC: begin
        result_d = AluResult;
        zero_d   = AluZero;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (|(RspReady & owner_q)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      src_a_q  <= '0;
      src_b_q  <= '0;
      ctrl_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      src_a_q  <= src_a_d;
      src_b_q  <= src_b_d;
      ctrl_q   <= ctrl_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign RspValid   = (state_q == ST_RESP) ? owner_q : '0;
  assign RspResult  = result_q;
  assign RspZero    = zero_q;
  assign AluSrcA    = src_a_q;
  assign AluSrcB    = src_b_q;
  assign AluControl = ctrl_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int NREQ  = 2;
  localparam int WIDTH = 32;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       ReqValid, ReqReady, RspValid, RspReady;
  logic [NREQ*WIDTH-1:0] ReqSrcA, ReqSrcB;
  logic [NREQ*3-1:0]     ReqALUControl;
  logic [WIDTH-1:0]      RspResult, AluSrcA, AluSrcB, AluResult;
  logic                  RspZero, AluZero;
  logic [2:0]            AluControl;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .ReqValid      (ReqValid),
    .ReqReady      (ReqReady),
    .ReqSrcA       (ReqSrcA),
    .ReqSrcB       (ReqSrcB),
    .ReqALUControl (ReqALUControl),
    .RspValid      (RspValid),
    .RspReady      (RspReady),
    .RspResult     (RspResult),
    .RspZero       (RspZero),
    .AluSrcA       (AluSrcA),
    .AluSrcB       (AluSrcB),
    .AluControl    (AluControl),
    .AluResult     (AluResult),
    .AluZero       (AluZero)
  );

  function automatic logic [WIDTH-1:0] alu_eval(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                input logic [2:0] op);
    case (op)
      ALU_OP_AND: return a & b;
      ALU_OP_OR:  return a | b;
      ALU_OP_ADD: return a + b;
      ALU_OP_SUB: return a - b;
      ALU_OP_MUL: return a * b;
      ALU_OP_SLT: return ($signed(a) < $signed(b)) ? 1 : 0;
      3'd3:       return a ^ b;
      default:    return ~a;
    endcase
  endfunction

  // Stand-in for the external combinational ALU.
  always_comb begin
    AluResult = alu_eval(AluSrcA, AluSrcB, AluControl);
    AluZero   = (AluResult == '0);
  end

  // Transaction model: one operation in flight, age 0 = evaluating, 1 = responding.
  bit               m_busy  = 1'b0;
  int               m_age   = 0;
  int               m_owner = 0;
  int               m_ptr   = 0;
  logic [WIDTH-1:0] m_a = '0, m_b = '0, m_res = '0;
  logic [2:0]       m_op   = '0;
  logic             m_zero = 1'b0;

  function automatic int model_grant(input logic [NREQ-1:0] v);
    int start;
`ifdef ALU_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = m_ptr;
`endif
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (start + k) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic checkVal(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    logic [NREQ-1:0] exp_rdy, exp_rsp;
    int g;
    g       = model_grant(ReqValid);
    exp_rdy = '0;
    exp_rsp = '0;
    if (!reset && !m_busy && g >= 0) exp_rdy[g] = 1'b1;
    if (m_busy && m_age == 1) exp_rsp[m_owner] = 1'b1;
    checkVal("ReqReady",   ReqReady,   exp_rdy);
    checkVal("RspValid",   RspValid,   exp_rsp);
    checkVal("RspResult",  RspResult,  m_res);
    checkVal("RspZero",    RspZero,    m_zero);
    checkVal("AluSrcA",    AluSrcA,    m_a);
    checkVal("AluSrcB",    AluSrcB,    m_b);
    checkVal("AluControl", AluControl, m_op);
  endtask

  task automatic modelUpdate();
    int g;
    g = model_grant(ReqValid);
    if (reset) begin
      m_busy = 1'b0; m_age = 0; m_owner = 0; m_ptr = 0;
      m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_zero = 1'b0;
    end else if (!m_busy) begin
      if (g >= 0) begin
        m_busy  = 1'b1;
        m_age   = 0;
        m_owner = g;
        m_a     = ReqSrcA[g*WIDTH +: WIDTH];
        m_b     = ReqSrcB[g*WIDTH +: WIDTH];
        m_op    = ReqALUControl[g*3 +: 3];
        m_ptr   = (g + 1) % NREQ;
      end
    end else if (m_age == 0) begin
      m_res  = alu_eval(m_a, m_b, m_op);
      m_zero = (m_res == '0);
      m_age  = 1;
    end else if (RspReady[m_owner]) begin
      m_busy = 1'b0;
    end
  endtask

  task automatic tick();
    #1;
    checkOutput();
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic rst, input logic [NREQ-1:0] v,
                               input logic [NREQ*WIDTH-1:0] a, input logic [NREQ*WIDTH-1:0] b,
                               input logic [NREQ*3-1:0] op, input logic [NREQ-1:0] rr);
    reset         = rst;
    ReqValid      = v;
    ReqSrcA       = a;
    ReqSrcB       = b;
    ReqALUControl = op;
    RspReady      = rr;
  endtask

  initial begin
    logic [NREQ*WIDTH-1:0] ra, rb;
    logic [NREQ*3-1:0]     rop;
    logic [NREQ-1:0]       exp_g;
    int                    g;

    applyStimulus(1'b1, 2'b11, '0, '0, '0, 2'b11);
    @(negedge clk);

    // Reset holds ReqReady low even with requests pending.
    #1;
    checkVal("rst_ReqReady", ReqReady, 0);
    checkVal("rst_RspValid", RspValid, 0);
    checkVal("rst_AluSrcA",  AluSrcA,  0);
    tick();
    tick();

    // Single ADD from requester 0.
    applyStimulus(1'b0, 2'b01, {32'd0, 32'd5}, {32'd0, 32'd7}, {3'd0, ALU_OP_ADD}, 2'b11);
    #1 checkVal("add_grant", ReqReady, 2'b01);
    tick();
    applyStimulus(1'b0, 2'b00, {32'd0, 32'd5}, {32'd0, 32'd7}, {3'd0, ALU_OP_ADD}, 2'b11);
    #1;
    checkVal("add_exec_RspValid", RspValid, 0);
    checkVal("add_exec_AluSrcA", AluSrcA, 5);
    checkVal("add_exec_AluControl", AluControl, 2);
    tick();
    #1;
    checkVal("add_RspValid", RspValid, 2'b01);
    checkVal("add_RspResult", RspResult, 12);
    checkVal("add_RspZero", RspZero, 0);
    tick();
    #1 checkVal("add_done_RspValid", RspValid, 0);
    tick();

    // Contention from a fresh pointer.
    applyStimulus(1'b1, 2'b00, '0, '0, '0, 2'b11);
    tick();
    applyStimulus(1'b0, 2'b11, {32'hF0, 32'd9}, {32'h0F, 32'd9}, {ALU_OP_OR, ALU_OP_SUB}, 2'b11);
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      g = 0;
`else
      g = k % 2;
`endif
      exp_g = '0;
      exp_g[g] = 1'b1;
      #1 checkVal("cont_grant", ReqReady, exp_g);
      tick();
      tick();
      #1;
      checkVal("cont_RspResult", RspResult, (g == 0) ? 32'h0 : 32'hFF);
      checkVal("cont_RspZero", RspZero, (g == 0) ? 1 : 0);
      tick();
    end

    // Backpressure on requester 1.
    applyStimulus(1'b0, 2'b10, {32'd3, 32'd0}, {32'd8, 32'd0}, {ALU_OP_SLT, 3'd0}, 2'b00);
    #1 checkVal("bp_grant", ReqReady, 2'b10);
    tick();
    tick();
    applyStimulus(1'b0, 2'b11, {32'd3, 32'd0}, {32'd8, 32'd0}, {ALU_OP_SLT, 3'd0}, 2'b00);
    for (int k = 0; k < 4; k++) begin
      #1;
      checkVal("bp_RspValid", RspValid, 2'b10);
      checkVal("bp_RspResult", RspResult, 1);
      checkVal("bp_ReqReady", ReqReady, 0);
      tick();
    end
    applyStimulus(1'b0, 2'b00, '0, '0, '0, 2'b10);
    tick();
    #1 checkVal("bp_release", RspValid, 0);
    tick();

    // Ready from the wrong requester must not complete the response.
    applyStimulus(1'b0, 2'b01, {32'd0, 32'd1}, {32'd0, 32'd1}, {3'd0, ALU_OP_ADD}, 2'b10);
    #1 checkVal("wo_grant", ReqReady, 2'b01);
    tick();
    applyStimulus(1'b0, 2'b00, '0, '0, '0, 2'b10);
    tick();
    for (int k = 0; k < 2; k++) begin
      #1 checkVal("wo_RspValid", RspValid, 2'b01);
      tick();
    end
    applyStimulus(1'b0, 2'b00, '0, '0, '0, 2'b01);
    tick();
    #1 checkVal("wo_done", RspValid, 0);
    tick();

    // Reset during EXEC of a MUL discards it.
    applyStimulus(1'b0, 2'b01, {32'd0, 32'd6}, {32'd0, 32'd7}, {3'd0, ALU_OP_MUL}, 2'b11);
    #1 checkVal("mul_grant", ReqReady, 2'b01);
    tick();
    applyStimulus(1'b1, 2'b00, '0, '0, '0, 2'b11);
    #1 checkVal("mul_exec_AluControl", AluControl, 5);
    tick();
    applyStimulus(1'b0, 2'b00, '0, '0, '0, 2'b11);
    #1;
    checkVal("mrst_RspValid", RspValid, 0);
    checkVal("mrst_RspResult", RspResult, 0);
    checkVal("mrst_AluSrcA", AluSrcA, 0);
    checkVal("mrst_AluSrcB", AluSrcB, 0);
    checkVal("mrst_AluControl", AluControl, 0);
    tick();
    tick();
    applyStimulus(1'b0, 2'b10, {32'd2, 32'd0}, {32'd3, 32'd0}, {ALU_OP_ADD, 3'd0}, 2'b11);
    #1 checkVal("mrst_req1_grant", ReqReady, 2'b10);
    tick();
    tick();
    #1 checkVal("mrst_req1_result", RspResult, 5);
    tick();
    tick();

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        ra[i*WIDTH +: WIDTH] = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 15)) : $urandom;
        rb[i*WIDTH +: WIDTH] = ($urandom_range(0, 3) == 0) ? ra[i*WIDTH +: WIDTH] : $urandom;
        rop[i*3 +: 3]        = 3'($urandom_range(0, 7));
      end
      applyStimulus(($urandom_range(0, 49) == 0), NREQ'($urandom), ra, rb, rop, NREQ'($urandom));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
